// File: rtl/mips_cpu_mem_access.sv
// Data-memory access stage: runs one load or store as an Avalon-MM master and stalls the core while busy.
// Loads return the raw aligned word plus addr[1:0]; lane extraction happens in the regfile.
module mips_cpu_mem_access #(
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic [1:0]  vaddr,
   output logic        misaligned,
   output logic        bus_err,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   localparam logic [5:0] OP_LB  = 6'b100000, OP_LH  = 6'b100001, OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LHU = 6'b100101, OP_SB  = 6'b101000, OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam int CW = $clog2(WAIT_TIMEOUT + 2);
   localparam logic [CW-1:0] WAIT_LAST = (WAIT_TIMEOUT == 0) ? '0 : CW'(WAIT_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, READ, READ_DATA, WRITE, FINISH} state_t;
   typedef enum logic [1:0] {RES_OK, RES_MIS, RES_ERR} res_t;

   state_t        state, state_n;
   res_t          res, res_n;
   logic [CW-1:0] wait_cnt, cnt_n;
   logic          is_load, is_store, fault, timeout_hit;
   logic          latch_req, latch_va, capture;
   logic [3:0]    be_n;
   logic [31:0]   wd_n;

   // lb..lwr occupy 100000-100110; 100111 is not a load
   assign is_load     = (opcode[5:3] == 3'b100) && (opcode[2:0] != 3'b111);
   assign is_store    = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
   assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

   always_comb begin
      fault = 1'b0;
      case (opcode)
         OP_LH, OP_LHU, OP_SH: fault = addr[0];
         OP_LW, OP_SW:         fault = |addr[1:0];
         default:              fault = 1'b0;
      endcase
   end

   always_comb begin
      be_n = 4'b1111;
      wd_n = '0;
      case (opcode)
         OP_SB: begin
            be_n = 4'b0001 << addr[1:0];
            wd_n = {4{store_data[7:0]}};
         end
         OP_SH: begin
            be_n = addr[1] ? 4'b1100 : 4'b0011;
            wd_n = {2{store_data[15:0]}};
         end
         OP_SW:   wd_n = store_data;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      res_n      = res;
      cnt_n      = wait_cnt;
      latch_req  = 1'b0;
      latch_va   = 1'b0;
      capture    = 1'b0;
      avm_read   = 1'b0;
      avm_write  = 1'b0;
      done       = 1'b0;
      misaligned = 1'b0;
      bus_err    = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (start && (is_load || is_store)) begin
               latch_va = 1'b1;
               if (fault) begin
                  state_n = FINISH;
                  res_n   = RES_MIS;
               end else begin
                  state_n   = is_load ? READ : WRITE;
                  res_n     = RES_OK;
                  latch_req = 1'b1;
               end
            end
         end
         READ, WRITE: begin
            avm_read  = (state == READ);
            avm_write = (state == WRITE);
            if (!avm_waitrequest) begin
               state_n = (state == READ) ? READ_DATA : FINISH;
               cnt_n   = '0;
            end else if (timeout_hit) begin
               // abandon the access; load_data keeps its previous value
               state_n = FINISH;
               res_n   = RES_ERR;
               cnt_n   = '0;
            end else begin
               cnt_n = wait_cnt + CW'(1);
            end
         end
         READ_DATA: begin
            capture = 1'b1;
            state_n = FINISH;
         end
         FINISH: begin
            done       = (res == RES_OK);
            misaligned = (res == RES_MIS);
            bus_err    = (res == RES_ERR);
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res            <= RES_OK;
         wait_cnt       <= '0;
         load_data      <= '0;
         vaddr          <= '0;
         avm_address    <= '0;
         avm_byteenable <= '0;
         avm_writedata  <= '0;
      end else begin
         res      <= res_n;
         wait_cnt <= cnt_n;
         if (latch_va) vaddr <= addr[1:0];
         if (latch_req) begin
            avm_address    <= {addr[31:2], 2'b00};
            avm_byteenable <= be_n;
            avm_writedata  <= wd_n;
         end
         if (capture) load_data <= avm_readdata;
      end
   end

endmodule

// File: tb/tb_mips_cpu_mem_access.sv
// Scoreboard bench for mips_cpu_mem_access: directed accesses against a simple Avalon slave model.
module tb_mips_cpu_mem_access;
   localparam logic [5:0] LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100, LWR = 6'b100110;
   localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
   localparam logic [2:0] K_DONE = 3'b001, K_MIS = 3'b010, K_ERR = 3'b100;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [5:0] opcode = '0;
   logic [31:0] addr = '0, store_data = '0;
   logic busy, done, misaligned, bus_err, avm_read, avm_write;
   logic [31:0] load_data, avm_address, avm_writedata;
   logic [1:0] vaddr;
   logic [3:0] avm_byteenable;
   logic avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = '0;

   mips_cpu_mem_access #(.WAIT_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr),
      .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
      .vaddr(vaddr), .misaligned(misaligned), .bus_err(bus_err),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] kind; logic [31:0] ld; logic chk_va; logic [1:0] va;
      int lat; int rdc; int wrc;
   } rsp_t;
   typedef struct { logic [31:0] a; logic [3:0] be; logic wr; logic [31:0] wd; } bus_t;
   rsp_t rq[$];
   bus_t bq[$];

   int checks = 0, passes = 0;
   int cyc = 0, start_cyc = 0, rd_cnt = 0, wr_cnt = 0;
   int nwait = 0;
   logic stuck = 1'b0, rd_pend = 1'b0;
   logic [31:0] slave_rdata = '0, last_ld = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic exp_rsp(input logic [2:0] k, input logic chk_va, input logic [1:0] va,
                          input int lat, input int rdc, input int wrc);
      rsp_t r;
      r.kind = k; r.ld = last_ld; r.chk_va = chk_va; r.va = va;
      r.lat = lat; r.rdc = rdc; r.wrc = wrc;
      rq.push_back(r);
   endtask

   task automatic exp_bus(input logic [31:0] a, input logic [3:0] be, input logic wr, input logic [31:0] wd);
      bus_t b;
      b.a = a; b.be = be; b.wr = wr; b.wd = wd;
      bq.push_back(b);
   endtask

   // start stays high for 1+hold cycles; the extra cycles carry a store opcode that must be ignored
   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input int hold);
      @(negedge clk);
      start = 1'b1; opcode = op; addr = a; store_data = d;
      start_cyc = cyc; rd_cnt = 0; wr_cnt = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         opcode = SW;
      end
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      if (busy) begin
         checks++;
         $display("FAIL idle_wait: busy still %b after 40 cycles, required 0", busy);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // slave: nwait waitrequest cycles per request (or forever when stuck), readdata one cycle after acceptance
   initial forever begin
      int wcnt;
      @(negedge clk);
      avm_readdata = rd_pend ? slave_rdata : 32'hBAD0_BAD0;
      rd_pend = 1'b0;
      if (avm_read || avm_write) begin
         if (stuck || wcnt < nwait) begin
            avm_waitrequest = 1'b1;
            wcnt++;
         end else begin
            avm_waitrequest = 1'b0;
            wcnt = 0;
            rd_pend = avm_read;
         end
      end else begin
         avm_waitrequest = 1'b0;
         wcnt = 0;
      end
   end

   // bus monitor: every request cycle must match the head of the bus queue
   initial forever begin
      logic prev_req;
      @(negedge clk);
      #1;
      if (avm_read) rd_cnt++;
      if (avm_write) wr_cnt++;
      if (avm_read || avm_write) begin
         if (bq.size() == 0) begin
            checks++;
            $display("FAIL bus_unexpected: read=%b write=%b addr=%h, required no request", avm_read, avm_write, avm_address);
         end else begin
            chk("bus_addr", avm_address, bq[0].a);
            chk("bus_be", {28'd0, avm_byteenable}, {28'd0, bq[0].be});
            chk("bus_dir", {31'd0, avm_write}, {31'd0, bq[0].wr});
            if (bq[0].wr) chk("bus_wdata", avm_writedata, bq[0].wd);
         end
      end else if (prev_req && bq.size() != 0) begin
         void'(bq.pop_front());
      end
      prev_req = avm_read || avm_write;
   end

   // response monitor
   initial forever begin
      rsp_t r;
      @(negedge clk);
      #1;
      if (done || misaligned || bus_err) begin
         if (rq.size() == 0) begin
            checks++;
            $display("FAIL rsp_unexpected: done=%b misaligned=%b bus_err=%b, required none", done, misaligned, bus_err);
         end else begin
            r = rq.pop_front();
            chk("rsp_kind", {29'd0, bus_err, misaligned, done}, {29'd0, r.kind});
            chk("rsp_busy", {31'd0, busy}, 32'd1);
            chk("rsp_load_data", load_data, r.ld);
            if (r.chk_va) chk("rsp_vaddr", {30'd0, vaddr}, {30'd0, r.va});
            chk("rsp_latency", cyc - start_cyc, r.lat);
            chk("rsp_read_cycles", rd_cnt, r.rdc);
            chk("rsp_write_cycles", wr_cnt, r.wrc);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ctrl", {26'd0, busy, done, misaligned, bus_err, avm_read, avm_write}, 32'd0);
      chk("reset_load_data", load_data, 32'd0);
      chk("reset_addr", avm_address, 32'd0);
      chk("reset_be_vaddr", {26'd0, avm_byteenable, vaddr}, 32'd0);
      chk("reset_wdata", avm_writedata, 32'd0);
      rst = 1'b0;

      // lw, no wait
      slave_rdata = 32'hDEAD_BEEF; nwait = 0; last_ld = 32'hDEAD_BEEF;
      exp_bus(32'h100, 4'b1111, 1'b0, 32'h0); exp_rsp(K_DONE, 1'b1, 2'd0, 3, 1, 0);
      issue(LW, 32'h100, 32'h0, 0);
      // sb to top lane
      exp_bus(32'h200, 4'b1000, 1'b1, 32'hA5A5_A5A5); exp_rsp(K_DONE, 1'b0, 2'd0, 2, 0, 1);
      issue(SB, 32'h203, 32'h0000_00A5, 0);
      // sh upper half with 3 waits
      nwait = 3;
      exp_bus(32'h200, 4'b1100, 1'b1, 32'hCAFE_CAFE); exp_rsp(K_DONE, 1'b0, 2'd0, 5, 0, 4);
      issue(SH, 32'h202, 32'h1234_CAFE, 0);
      // alignment faults: no bus cycle
      nwait = 0;
      exp_rsp(K_MIS, 1'b0, 2'd0, 1, 0, 0); issue(LW, 32'h101, 32'h0, 0);
      exp_rsp(K_MIS, 1'b0, 2'd0, 1, 0, 0); issue(LH, 32'h103, 32'h0, 0);
      exp_rsp(K_MIS, 1'b0, 2'd0, 1, 0, 0); issue(SH, 32'h201, 32'h0, 0);
      // timeout: read held 4 cycles, load_data unchanged
      stuck = 1'b1; slave_rdata = 32'h0BAD_0BAD;
      exp_bus(32'h304, 4'b1111, 1'b0, 32'h0); exp_rsp(K_ERR, 1'b0, 2'd0, 5, 4, 0);
      issue(LBU, 32'h307, 32'h0, 0);
      stuck = 1'b0;
      // lwr never faults, full byteenable
      slave_rdata = 32'hA1B2_C3D4; last_ld = 32'hA1B2_C3D4;
      exp_bus(32'h400, 4'b1111, 1'b0, 32'h0); exp_rsp(K_DONE, 1'b1, 2'd1, 3, 1, 0);
      issue(LWR, 32'h401, 32'h0, 0);
      // lh upper half with 2 waits
      nwait = 2; slave_rdata = 32'h5566_7788; last_ld = 32'h5566_7788;
      exp_bus(32'h100, 4'b1111, 1'b0, 32'h0); exp_rsp(K_DONE, 1'b1, 2'd2, 5, 3, 0);
      issue(LH, 32'h102, 32'h0, 0);
      // sb lane 0, sw with 1 wait
      nwait = 0;
      exp_bus(32'h010, 4'b0001, 1'b1, 32'h5A5A_5A5A); exp_rsp(K_DONE, 1'b0, 2'd0, 2, 0, 1);
      issue(SB, 32'h010, 32'h1234_565A, 0);
      nwait = 1;
      exp_bus(32'h008, 4'b1111, 1'b1, 32'h1122_3344); exp_rsp(K_DONE, 1'b0, 2'd0, 3, 0, 2);
      issue(SW, 32'h008, 32'h1122_3344, 0);
      // start held while busy must not queue a second access
      nwait = 2; slave_rdata = 32'h0BAD_F00D; last_ld = 32'h0BAD_F00D;
      exp_bus(32'h020, 4'b1111, 1'b0, 32'h0); exp_rsp(K_DONE, 1'b1, 2'd0, 5, 3, 0);
      issue(LW, 32'h020, 32'h0, 1);

      // reset during a stalled read
      stuck = 1'b1;
      exp_bus(32'h500, 4'b1111, 1'b0, 32'h0);
      @(negedge clk);
      start = 1'b1; opcode = LW; addr = 32'h500;
      @(negedge clk);
      start = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_read", {31'd0, avm_read}, 32'd0);
      chk("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0; stuck = 1'b0; nwait = 0; last_ld = 32'h0;

      // unknown opcode is ignored
      @(negedge clk);
      start = 1'b1; opcode = 6'b001000; addr = 32'h0;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("unknown_op_idle", {30'd0, busy, avm_read | avm_write}, 32'd0);

      // recovery after reset
      exp_bus(32'h000, 4'b1000, 1'b1, 32'h7777_7777); exp_rsp(K_DONE, 1'b0, 2'd0, 2, 0, 1);
      issue(SB, 32'h003, 32'h0000_0077, 0);
      slave_rdata = 32'h1234_5678; last_ld = 32'h1234_5678;
      exp_bus(32'h400, 4'b1111, 1'b0, 32'h0); exp_rsp(K_DONE, 1'b1, 2'd0, 3, 1, 0);
      issue(LW, 32'h400, 32'h0, 0);

      repeat (3) @(negedge clk);
      chk("rsp_queue_drained", rq.size(), 32'd0);
      chk("bus_queue_drained", bq.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
